reg_write_arbiter: RTL and testbench

- Shares the single write port of the 16x8 register file (WA, ALUResult, write_enable) between two write requesters.
- Requester 0 is the ALU writeback; requester 1 is the load/immediate path.
- Arbitrates round-robin and registers the winning write into a one-entry issue stage that drives the register file.
- Exposes forwarding flags/data so read ports RA1/RA2 see a write still in flight.

---
 rtl/reg_write_arbiter_if.sv | 41 ++++
 rtl/reg_write_arbiter.sv | 77 +++++++
 tb/tb_reg_write_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/reg_write_arbiter_if.sv
// Write-request, register-file write-port and forwarding signals of reg_write_arbiter.
// Handshake: a write transfers on a rising clk edge where reqN_valid & reqN_ready are both 1.
// A requester holds valid/addr/data stable until it sees ready.
interface reg_write_arbiter_if #(
   parameter int AW = 4,
   parameter int DW = 8
);
   logic          req0_valid;
   logic [AW-1:0] req0_addr;
   logic [DW-1:0] req0_data;
   logic          req0_ready;
   logic          req1_valid;
   logic [AW-1:0] req1_addr;
   logic [DW-1:0] req1_data;
   logic          req1_ready;
   logic          rf_hold;
   logic [AW-1:0] rf_wa;
   logic [DW-1:0] rf_wd;
   logic          rf_we;
   logic [AW-1:0] ra1;
   logic [AW-1:0] ra2;
   logic          fwd1_hit;
   logic          fwd2_hit;
   logic [DW-1:0] fwd_data;
   logic          dbg_stage_valid;
   logic          dbg_rr_ptr;

   modport master (
      output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
             rf_hold, ra1, ra2,
      input  req0_ready, req1_ready, rf_wa, rf_wd, rf_we, fwd1_hit, fwd2_hit, fwd_data,
             dbg_stage_valid, dbg_rr_ptr
   );

   modport slave (
      input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
             rf_hold, ra1, ra2,
      output req0_ready, req1_ready, rf_wa, rf_wd, rf_we, fwd1_hit, fwd2_hit, fwd_data,
             dbg_stage_valid, dbg_rr_ptr
   );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU (req0)
// and the load/immediate path (req1), with a one-entry issue stage and forwarding.
module reg_write_arbiter #(
   parameter int AW = 4,
   parameter int DW = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   reg_write_arbiter_if.slave bus
);

   logic          stage_valid_q, stage_valid_d;
   logic [AW-1:0] stage_addr_q,  stage_addr_d;
   logic [DW-1:0] stage_data_q,  stage_data_d;
   logic          rr_ptr_q,      rr_ptr_d;

   logic can_acc;
   logic grant0;
   logic grant1;
   logic we;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stage_valid_q <= 1'b0;
         stage_addr_q  <= '0;
         stage_data_q  <= '0;
         rr_ptr_q      <= 1'b0;
      end else begin
         stage_valid_q <= stage_valid_d;
         stage_addr_q  <= stage_addr_d;
         stage_data_q  <= stage_data_d;
         rr_ptr_q      <= rr_ptr_d;
      end
   end

   // Grants are gated by reset_n so no requester sees ready while reset is held.
   always_comb begin
      we      = stage_valid_q & ~bus.rf_hold;
      can_acc = (~stage_valid_q | ~bus.rf_hold) & reset_n;
      grant0  = can_acc & bus.req0_valid & (~bus.req1_valid | ~rr_ptr_q);
      grant1  = can_acc & bus.req1_valid & (~bus.req0_valid |  rr_ptr_q);

      stage_valid_d = stage_valid_q;
      stage_addr_d  = stage_addr_q;
      stage_data_d  = stage_data_q;
      rr_ptr_d      = rr_ptr_q;

      if (we) begin
         stage_valid_d = 1'b0;
      end
      if (grant0) begin
         stage_valid_d = 1'b1;
         stage_addr_d  = bus.req0_addr;
         stage_data_d  = bus.req0_data;
         rr_ptr_d      = 1'b1;
      end else if (grant1) begin
         stage_valid_d = 1'b1;
         stage_addr_d  = bus.req1_addr;
         stage_data_d  = bus.req1_data;
         rr_ptr_d      = 1'b0;
      end
   end

   always_comb begin
      bus.req0_ready      = grant0;
      bus.req1_ready      = grant1;
      bus.rf_we           = we;
      bus.rf_wa           = stage_valid_q ? stage_addr_q : '0;
      bus.rf_wd           = stage_valid_q ? stage_data_q : '0;
      bus.fwd1_hit        = stage_valid_q & (stage_addr_q == bus.ra1);
      bus.fwd2_hit        = stage_valid_q & (stage_addr_q == bus.ra2);
      bus.fwd_data        = stage_valid_q ? stage_data_q : '0;
      bus.dbg_stage_valid = stage_valid_q;
      bus.dbg_rr_ptr      = rr_ptr_q;
   end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: vector table per cycle plus a write scoreboard
// fed from the expected grants and drained on every observed register-file write.
module tb_reg_write_arbiter;

   logic clk;
   logic reset_n;

   reg_write_arbiter_if #(.AW(4), .DW(8)) bus ();

   reg_write_arbiter #(.AW(4), .DW(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Register file model written through the arbitrated port
   logic [7:0] rf_mem [16];
   always @(posedge clk) begin
      if (bus.rf_we) rf_mem[bus.rf_wa] <= bus.rf_wd;
   end

   typedef struct {
      int hold, v0, a0, d0, v1, a1, d1, ra1, ra2;
      int r0, r1, we, wa, wd, f1, f2, fd;
   } vec_t;

   vec_t        vecs [$];
   logic [11:0] exp_q [$];
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic sb_pop(input string name);
      logic [11:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: unexpected write wa=%0h wd=%0h, queue empty", name, bus.rf_wa, bus.rf_wd);
      end else begin
         e = exp_q.pop_front();
         chk(name, {20'd0, bus.rf_wa, bus.rf_wd}, {20'd0, e});
      end
   endtask

   task automatic drive(input vec_t v);
      bus.rf_hold    = v.hold[0];
      bus.req0_valid = v.v0[0];
      bus.req0_addr  = v.a0[3:0];
      bus.req0_data  = v.d0[7:0];
      bus.req1_valid = v.v1[0];
      bus.req1_addr  = v.a1[3:0];
      bus.req1_data  = v.d1[7:0];
      bus.ra1        = v.ra1[3:0];
      bus.ra2        = v.ra2[3:0];
   endtask

   task automatic add(input vec_t v);
      vecs.push_back(v);
   endtask

   initial begin
      vec_t v;
      for (int i = 0; i < 16; i++) rf_mem[i] = 8'h00;

      // Reset held with a pending request
      reset_n = 1'b0;
      drive('{0, 1, 2, 'h11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
      repeat (2) @(negedge clk);
      #2;
      chk("rst_ready0", {31'd0, bus.req0_ready}, 0);
      chk("rst_ready1", {31'd0, bus.req1_ready}, 0);
      chk("rst_we", {31'd0, bus.rf_we}, 0);
      chk("rst_wa", {28'd0, bus.rf_wa}, 0);
      chk("rst_fwd1", {31'd0, bus.fwd1_hit}, 0);
      chk("rst_fwd2", {31'd0, bus.fwd2_hit}, 0);
      chk("rst_fwd_data", {24'd0, bus.fwd_data}, 0);
      chk("rst_rr_ptr", {31'd0, bus.dbg_rr_ptr}, 0);

      // Release with contention: requester 0 wins first
      @(negedge clk);
      reset_n = 1'b1;
      bus.req1_valid = 1'b1; bus.req1_addr = 4'd8; bus.req1_data = 8'h88;
      #2;
      chk("rel_ready0", {31'd0, bus.req0_ready}, 1);
      chk("rel_ready1", {31'd0, bus.req1_ready}, 0);
      exp_q.push_back({4'd2, 8'h11});

      @(negedge clk);
      bus.req0_valid = 1'b0;
      #2;
      chk("rel2_ready1", {31'd0, bus.req1_ready}, 1);
      chk("rel2_we", {31'd0, bus.rf_we}, 1);
      if (bus.rf_we) sb_pop("rel2_sb");
      exp_q.push_back({4'd8, 8'h88});

      // Reset mid-write: rf_we must drop without a clock edge
      @(negedge clk);
      bus.req1_valid = 1'b0;
      #2;
      chk("mid_we_before", {31'd0, bus.rf_we}, 1);
      chk("mid_wa_before", {28'd0, bus.rf_wa}, 8);
      #1 reset_n = 1'b0;
      #1;
      chk("mid_we_async", {31'd0, bus.rf_we}, 0);
      exp_q.delete();
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #2;
         chk("post_rst_we", {31'd0, bus.rf_we}, 0);
      end

      //   hold v0 a0 d0     v1 a1 d1     ra1 ra2 r0 r1 we wa wd     f1 f2 fd
      add('{0, 1, 5, 13,    0, 0, 0,     5, 2,   1, 0, 0, 0, 0,     0, 0, 0});
      add('{0, 0, 0, 0,     0, 0, 0,     5, 2,   0, 0, 1, 5, 13,    1, 0, 13});
      add('{0, 0, 0, 0,     1, 4, 'h22,  5, 2,   0, 1, 0, 0, 0,     0, 0, 0});
      add('{0, 1, 1, 7,     1, 2, 9,     1, 2,   1, 0, 1, 4, 'h22,  0, 0, 'h22});
      add('{0, 1, 1, 7,     1, 2, 9,     1, 2,   0, 1, 1, 1, 7,     1, 0, 7});
      add('{0, 1, 1, 7,     1, 2, 9,     1, 2,   1, 0, 1, 2, 9,     0, 1, 9});
      add('{0, 1, 1, 7,     1, 2, 9,     1, 2,   0, 1, 1, 1, 7,     1, 0, 7});
      add('{0, 0, 0, 0,     0, 0, 0,     1, 2,   0, 0, 1, 2, 9,     0, 1, 9});
      add('{1, 1, 3, 'h55,  0, 0, 0,     3, 3,   1, 0, 0, 0, 0,     0, 0, 0});
      for (int i = 0; i < 3; i++)
         add('{1, 1, 6, 'h66, 1, 7, 'h77, 3, 3,  0, 0, 0, 3, 'h55,  1, 1, 'h55});
      add('{0, 1, 6, 'h66,  1, 7, 'h77,  3, 7,   0, 1, 1, 3, 'h55,  1, 0, 'h55});
      add('{0, 1, 6, 'h66,  1, 6, 'h99,  6, 7,   1, 0, 1, 7, 'h77,  0, 1, 'h77});
      add('{0, 0, 0, 0,     1, 6, 'h99,  6, 7,   0, 1, 1, 6, 'h66,  1, 0, 'h66});
      add('{0, 0, 0, 0,     0, 0, 0,     6, 0,   0, 0, 1, 6, 'h99,  1, 0, 'h99});
      add('{0, 1, 0, 'hff,  0, 0, 0,     6, 0,   1, 0, 0, 0, 0,     0, 0, 0});
      add('{0, 0, 0, 0,     0, 0, 0,     6, 0,   0, 0, 1, 0, 'hff,  0, 1, 'hff});
      add('{0, 0, 0, 0,     0, 0, 0,     6, 0,   0, 0, 0, 0, 0,     0, 0, 0});

      foreach (vecs[i]) begin
         v = vecs[i];
         @(negedge clk);
         drive(v);
         #2;
         chk($sformatf("v%0d_ready0", i), {31'd0, bus.req0_ready}, v.r0);
         chk($sformatf("v%0d_ready1", i), {31'd0, bus.req1_ready}, v.r1);
         chk($sformatf("v%0d_we", i), {31'd0, bus.rf_we}, v.we);
         chk($sformatf("v%0d_wa", i), {28'd0, bus.rf_wa}, v.wa);
         chk($sformatf("v%0d_wd", i), {24'd0, bus.rf_wd}, v.wd);
         chk($sformatf("v%0d_fwd1", i), {31'd0, bus.fwd1_hit}, v.f1);
         chk($sformatf("v%0d_fwd2", i), {31'd0, bus.fwd2_hit}, v.f2);
         chk($sformatf("v%0d_fwd_data", i), {24'd0, bus.fwd_data}, v.fd);
         if (bus.rf_we) sb_pop($sformatf("v%0d_sb", i));
         if (v.r0 != 0) exp_q.push_back({v.a0[3:0], v.d0[7:0]});
         if (v.r1 != 0) exp_q.push_back({v.a1[3:0], v.d1[7:0]});
      end

      @(negedge clk);
      chk("sb_drained", exp_q.size(), 0);
      chk("rf_mem5", {24'd0, rf_mem[5]}, 13);
      chk("rf_mem3", {24'd0, rf_mem[3]}, 'h55);
      chk("rf_mem6_overwrite", {24'd0, rf_mem[6]}, 'h99);
      chk("rf_mem0", {24'd0, rf_mem[0]}, 'hff);
      chk("rf_mem8_discarded", {24'd0, rf_mem[8]}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
